// File: rtl/unbiased_rounding_pkg.sv
// Shared helpers for the convergent rounder and the adder-tree truncate path.
package unbiased_rounding_pkg;

    // Largest value representable in width_out bits, returned zero-extended to 64 bits.
    function automatic logic [63:0] sat_limit(input int width_out, input bit is_signed);
        logic [63:0] lim;
        if (is_signed) begin
            lim = (64'd1 << (width_out - 1)) - 64'd1;
        end else if (width_out >= 64) begin
            lim = '1;
        end else begin
            lim = (64'd1 << width_out) - 64'd1;
        end
        return lim;
    endfunction

endpackage

// File: rtl/unbiased_rounding_core.sv
// Combinational round-half-to-even with saturation at the top of the output range.
module unbiased_rounding_core
    import unbiased_rounding_pkg::*;
#(
    parameter int WIDTH_IN  = 0,
    parameter int WIDTH_OUT = 0,
    parameter bit IS_SIGNED = 1'b1
) (
    input  logic [WIDTH_IN-1:0]  din_i,
    output logic [WIDTH_OUT-1:0] rnd_o,
    output logic                 sat_o
);

    localparam int D = WIDTH_IN - WIDTH_OUT;

    generate
        if (D == 0) begin : g_pass
            assign rnd_o = din_i;
            assign sat_o = 1'b0;
        end else if (D > 0) begin : g_round
            localparam logic [63:0]          LIMIT64 = sat_limit(WIDTH_OUT, IS_SIGNED);
            localparam logic [WIDTH_OUT-1:0] LIMIT   = LIMIT64[WIDTH_OUT-1:0];
            localparam logic [D-1:0]         HALF    = D'(1) << (D - 1);

            logic [WIDTH_OUT-1:0] keep;
            logic [D-1:0]         frac;
            logic                 up;
            logic                 at_max;

            // keep is the floor value for both signednesses; only the limit differs.
            assign keep   = din_i[WIDTH_IN-1:D];
            assign frac   = din_i[D-1:0];
            assign up     = (frac > HALF) || ((frac == HALF) && keep[0]);
            assign at_max = (keep == LIMIT);
            assign sat_o  = up && at_max;
            assign rnd_o  = (up && !at_max) ? keep + 1'b1 : keep;
        end
    endgenerate

endmodule

// File: rtl/unbiased_rounding.sv
// Registered convergent rounder. Define UNBIASED_ROUNDING_OVF_EN to add the ovf output.
module unbiased_rounding
    import unbiased_rounding_pkg::*;
#(
    parameter int WIDTH_IN  = 0,
    parameter int WIDTH_OUT = 0,
    parameter bit IS_SIGNED = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [WIDTH_IN-1:0]  din,
    output logic [WIDTH_OUT-1:0] dout
`ifdef UNBIASED_ROUNDING_OVF_EN
    ,
    output logic                 ovf
`endif
);

    generate
        if (WIDTH_IN <= 0) begin : g_bad_in
            $error("unbiased_rounding: WIDTH_IN must be > 0");
        end
        if (WIDTH_OUT <= 0) begin : g_bad_out
            $error("unbiased_rounding: WIDTH_OUT must be > 0");
        end
        if (WIDTH_OUT > WIDTH_IN) begin : g_bad_order
            $error("unbiased_rounding: WIDTH_OUT must be <= WIDTH_IN");
        end
    endgenerate

    logic [WIDTH_OUT-1:0] rnd;
    logic                 sat;
    logic [WIDTH_OUT-1:0] dout_d;
    logic [WIDTH_OUT-1:0] dout_q;

    unbiased_rounding_core #(
        .WIDTH_IN  (WIDTH_IN),
        .WIDTH_OUT (WIDTH_OUT),
        .IS_SIGNED (IS_SIGNED)
    ) u_core (
        .din_i (din),
        .rnd_o (rnd),
        .sat_o (sat)
    );

    always_comb begin
        dout_d = ena ? rnd : dout_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_q <= '0;
        end else begin
            dout_q <= dout_d;
        end
    end

    assign dout = dout_q;

`ifdef UNBIASED_ROUNDING_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // The flag describes the value currently held in dout, so it shares its enable.
    always_comb begin
        ovf_d = ena ? sat : ovf_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_sat;
    assign unused_sat = sat;
`endif

endmodule

// File: tb/tb_unbiased_rounding.sv
// Bench for unbiased_rounding: unsigned 6->4, signed 6->4 and 8->8 pass-through instances.
module tb_unbiased_rounding;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena   = 1'b0;
    logic [5:0] din_u = '0;
    logic [5:0] din_s = '0;
    logic [7:0] din_p = '0;
    logic [3:0] dout_u;
    logic [3:0] dout_s;
    logic [7:0] dout_p;
`ifdef UNBIASED_ROUNDING_OVF_EN
    logic ovf_u, ovf_s, ovf_p;
`endif

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    unbiased_rounding #(.WIDTH_IN(6), .WIDTH_OUT(4), .IS_SIGNED(1'b0)) u_uns (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din_u), .dout(dout_u)
`ifdef UNBIASED_ROUNDING_OVF_EN
        , .ovf(ovf_u)
`endif
    );

    unbiased_rounding #(.WIDTH_IN(6), .WIDTH_OUT(4), .IS_SIGNED(1'b1)) u_sgn (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din_s), .dout(dout_s)
`ifdef UNBIASED_ROUNDING_OVF_EN
        , .ovf(ovf_s)
`endif
    );

    unbiased_rounding #(.WIDTH_IN(8), .WIDTH_OUT(8), .IS_SIGNED(1'b0)) u_pass (
        .clk(clk), .rst_n(rst_n), .ena(ena), .din(din_p), .dout(dout_p)
`ifdef UNBIASED_ROUNDING_OVF_EN
        , .ovf(ovf_p)
`endif
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: real-valued v / 2^d rounded half-to-even, clamped at the top of the range.
    function automatic int model(input int v, input int d, input int wout, input bit sgn,
                                 output bit sat);
        int q, keep, frac, r, mx;
        sat = 1'b0;
        if (d == 0) return v;
        q    = 1 << d;
        keep = (v >= 0) ? v / q : -((-v + q - 1) / q);
        frac = v - keep * q;
        r    = keep;
        if (2 * frac > q || (2 * frac == q && keep % 2 != 0)) r = keep + 1;
        mx = sgn ? (1 << (wout - 1)) - 1 : (1 << wout) - 1;
        if (r > mx) begin
            r   = mx;
            sat = 1'b1;
        end
        return r;
    endfunction

    typedef struct {
        string name;
        bit    sgn;
        int    din;
        int    exp;
        bit    exp_ovf;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int  e_u, e_s, e_p;
        bit  s_u, s_s, s_p, dummy;

        tbl.push_back('{"u_1p5",    1'b0,   6,  2, 1'b0});
        tbl.push_back('{"u_2p5",    1'b0,  10,  2, 1'b0});
        tbl.push_back('{"u_2p75",   1'b0,  11,  3, 1'b0});
        tbl.push_back('{"u_2p25",   1'b0,   9,  2, 1'b0});
        tbl.push_back('{"u_0p5",    1'b0,   2,  0, 1'b0});
        tbl.push_back('{"u_3p5",    1'b0,  14,  4, 1'b0});
        tbl.push_back('{"u_15p75",  1'b0,  63, 15, 1'b1});
        tbl.push_back('{"u_15p5",   1'b0,  62, 15, 1'b1});
        tbl.push_back('{"u_zero",   1'b0,   0,  0, 1'b0});
        tbl.push_back('{"s_m1p5",   1'b1,  -6, -2, 1'b0});
        tbl.push_back('{"s_m2p5",   1'b1, -10, -2, 1'b0});
        tbl.push_back('{"s_m2p25",  1'b1,  -9, -2, 1'b0});
        tbl.push_back('{"s_7p5",    1'b1,  30,  7, 1'b1});
        tbl.push_back('{"s_7p75",   1'b1,  31,  7, 1'b1});
        tbl.push_back('{"s_min",    1'b1, -32, -8, 1'b0});
        tbl.push_back('{"s_m0p5",   1'b1,  -2,  0, 1'b0});
        tbl.push_back('{"s_0p5",    1'b1,   2,  0, 1'b0});
        tbl.push_back('{"s_6p5",    1'b1,  26,  6, 1'b0});

        // Reset holds every output at zero even with clocks and ena running.
        ena   = 1'b1;
        din_u = 6'd11;
        din_s = 6'd11;
        din_p = 8'h5A;
        #2;
        check("rst_u", int'(dout_u), 0);
        check("rst_s", int'(dout_s), 0);
        check("rst_p", int'(dout_p), 0);
        tick();
        tick();
        check("rst_clk_u", int'(dout_u), 0);
        check("rst_clk_p", int'(dout_p), 0);
`ifdef UNBIASED_ROUNDING_OVF_EN
        check("rst_ovf_u", int'(ovf_u), 0);
`endif
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            if (tbl[i].sgn) din_s = 6'(tbl[i].din);
            else            din_u = 6'(tbl[i].din);
            ena = 1'b1;
            tick();
            if (tbl[i].sgn) check(tbl[i].name, int'($signed(dout_s)), tbl[i].exp);
            else            check(tbl[i].name, int'(dout_u), tbl[i].exp);
`ifdef UNBIASED_ROUNDING_OVF_EN
            check({tbl[i].name, "_ovf"}, int'(tbl[i].sgn ? ovf_s : ovf_u), int'(tbl[i].exp_ovf));
`endif
        end

        // Enable/hold.
        din_u = 6'd10;
        ena   = 1'b1;
        tick();
        check("hold_load", int'(dout_u), 2);
        ena   = 1'b0;
        din_u = 6'd11;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold", int'(dout_u), 2);
        end
        ena = 1'b1;
        tick();
        check("hold_release", int'(dout_u), 3);

        // Asynchronous reset in the middle of the cycle, well away from any rising edge.
        ena = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_u", int'(dout_u), 0);
        check("async_rst_s", int'(dout_s), 0);
        #2;
        rst_n = 1'b1;
        din_u = 6'd6;
        ena   = 1'b1;
        tick();
        check("post_rst_u", int'(dout_u), 2);

        // Pass-through.
        din_p = 8'hA5;
        tick();
        check("pass_a5", int'(dout_p), 'hA5);

        // Randomized against the arithmetic model.
        e_u = 0; e_s = 0; e_p = 0;
        s_u = 0; s_s = 0; s_p = 0;
        for (int i = 0; i < 300; i++) begin
            din_u = 6'($urandom);
            din_s = 6'($urandom);
            din_p = 8'($urandom);
            ena   = (i == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            tick();
            if (ena) begin
                e_u = model(int'(din_u), 2, 4, 1'b0, s_u);
                e_s = model(int'($signed(din_s)), 2, 4, 1'b1, s_s);
                e_p = model(int'(din_p), 0, 8, 1'b0, s_p);
            end
            check("rand_u", int'(dout_u), e_u);
            check("rand_s", int'($signed(dout_s)), e_s);
            check("rand_p", int'(dout_p), e_p);
`ifdef UNBIASED_ROUNDING_OVF_EN
            check("rand_ovf_u", int'(ovf_u), int'(s_u));
            check("rand_ovf_s", int'(ovf_s), int'(s_s));
            check("rand_ovf_p", int'(ovf_p), int'(s_p));
`endif
        end
        dummy = s_p;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
